// File: rtl/hqc_loader_pkg.sv
// Shared sizes, address widths and FSM encoding for the HQC ciphertext/secret-key stream loader.
`timescale 1ns/1ps
package hqc_loader_pkg;

    localparam int unsigned CT_BYTES = 4481;
    localparam int unsigned SK_BYTES = 2296;
    localparam int unsigned SK_WORDS = SK_BYTES / 8;
    localparam int unsigned CT_AW    = 13;
    localparam int unsigned SK_AW    = 9;

    // Secret key is packed whole 64-bit words only; the top level refuses to elaborate otherwise.
    localparam bit SK_ALIGNED = ((SK_BYTES % 8) == 0);

    typedef enum logic [1:0] {
        S_CT     = 2'd0,
        S_SK     = 2'd1,
        S_DONE_P = 2'd2,
        LOADED   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/hqc_byte_packer64.sv
// Packs a byte stream little-endian into 64-bit words and strobes each completed word.
`timescale 1ns/1ps
module hqc_byte_packer64 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        lane_last_o,
    output logic        word_valid_o,
    output logic [63:0] word_o
);

    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [63:0] asm_q, asm_d;
    logic        word_valid_q, word_valid_d;
    logic [63:0] word_q, word_d;
    logic [63:0] lane_s;

    assign lane_last_o  = (byte_idx_q == 3'd7);
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

    // Lane insert and word completion; a clear discards any partial word.
    always_comb begin
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        lane_s       = asm_q;
        for (int k = 0; k < 8; k++) begin
            if (byte_idx_q == 3'(k)) begin
                lane_s[8*k +: 8] = byte_i;
            end else begin
                lane_s[8*k +: 8] = asm_q[8*k +: 8];
            end
        end
        if (clear_i) begin
            byte_idx_d = 3'd0;
            asm_d      = 64'h0;
        end else if (byte_valid_i) begin
            if (lane_last_o) begin
                word_valid_d = 1'b1;
                word_d       = lane_s;
                byte_idx_d   = 3'd0;
                asm_d        = 64'h0;
            end else begin
                byte_idx_d = byte_idx_q + 3'd1;
                asm_d      = lane_s;
            end
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    // Packer state and registered word output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_idx_q   <= 3'd0;
            asm_q        <= 64'h0;
            word_valid_q <= 1'b0;
            word_q       <= 64'h0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

endmodule

// File: rtl/hqc_stream_loader.sv
// UART byte-stream loader: ciphertext bytes to CT memory, then secret-key bytes packed into 64-bit words.
`timescale 1ns/1ps
module hqc_stream_loader
    import hqc_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rearm_i,
    output logic             ct_we_o,
    output logic [CT_AW-1:0] ct_addr_o,
    output logic [7:0]       ct_wdata_o,
    output logic             sk_we_o,
    output logic [SK_AW-1:0] sk_addr_o,
    output logic [63:0]      sk_wdata_o,
    output logic             busy_o,
    output logic             loaded_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned      IDLE_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    if (!SK_ALIGNED) begin : g_sk_align_check
        $error("SK_BYTES must be a multiple of 8");
    end

    loader_state_t    state_q, state_d;
    logic [CT_AW-1:0] ct_cnt_q, ct_cnt_d;
    logic [SK_AW-1:0] word_cnt_q, word_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic             busy_q, busy_d;
    logic             loaded_q, loaded_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ct_we_q, ct_we_d;
    logic [CT_AW-1:0] ct_addr_q, ct_addr_d;
    logic [7:0]       ct_wdata_q, ct_wdata_d;
    logic [SK_AW-1:0] sk_addr_q, sk_addr_d;
    logic             pack_valid_s, pack_clear_s, lane_last_s, timeout_s;

    hqc_byte_packer64 u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (pack_clear_s),
        .byte_valid_i (pack_valid_s),
        .byte_i       (rx_data_i),
        .lane_last_o  (lane_last_s),
        .word_valid_o (sk_we_o),
        .word_o       (sk_wdata_o)
    );

    // The idle timer only arms once a frame has started, so an idle line before the first byte never errors.
    assign timeout_s = busy_q && ((state_q == S_CT) || (state_q == S_SK)) && (idle_q == IDLE_LAST);

    // Next-state, counters and write-port decode.
    always_comb begin
        state_d      = state_q;
        ct_cnt_d     = ct_cnt_q;
        word_cnt_d   = word_cnt_q;
        idle_d       = idle_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        ct_we_d      = 1'b0;
        ct_addr_d    = ct_addr_q;
        ct_wdata_d   = ct_wdata_q;
        sk_addr_d    = sk_addr_q;
        pack_valid_s = 1'b0;
        pack_clear_s = 1'b0;
        loaded_d     = (state_q == LOADED) && !rearm_i;

        case (state_q)
            S_CT, S_SK: begin
                if (timeout_s) begin
                    err_d        = 1'b1;
                    busy_d       = 1'b0;
                    ct_cnt_d     = {CT_AW{1'b0}};
                    word_cnt_d   = {SK_AW{1'b0}};
                    idle_d       = {IDLE_W{1'b0}};
                    pack_clear_s = 1'b1;
                    state_d      = S_CT;
                end else if (rx_valid_i) begin
                    busy_d = 1'b1;
                    idle_d = {IDLE_W{1'b0}};
                    if (state_q == S_CT) begin
                        ct_we_d    = 1'b1;
                        ct_addr_d  = ct_cnt_q;
                        ct_wdata_d = rx_data_i;
                        if (ct_cnt_q == CT_AW'(CT_BYTES - 1)) begin
                            state_d = S_SK;
                        end else begin
                            ct_cnt_d = ct_cnt_q + CT_AW'(1);
                        end
                    end else begin
                        pack_valid_s = 1'b1;
                        if (lane_last_s) begin
                            sk_addr_d  = word_cnt_q;
                            word_cnt_d = word_cnt_q + SK_AW'(1);
                            if (word_cnt_q == SK_AW'(SK_WORDS - 1)) begin
                                state_d = S_DONE_P;
                            end else begin
                                state_d = S_SK;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q;
                        end
                    end
                end else if (busy_q) begin
                    idle_d = idle_q + IDLE_W'(1);
                end else begin
                    idle_d = {IDLE_W{1'b0}};
                end
            end
            S_DONE_P: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                idle_d  = {IDLE_W{1'b0}};
                state_d = LOADED;
            end
            LOADED: begin
                if (rearm_i) begin
                    ct_cnt_d     = {CT_AW{1'b0}};
                    word_cnt_d   = {SK_AW{1'b0}};
                    idle_d       = {IDLE_W{1'b0}};
                    pack_clear_s = 1'b1;
                    state_d      = S_CT;
                end else begin
                    state_d = LOADED;
                end
            end
            default: begin
                state_d = S_CT;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_CT;
            ct_cnt_q   <= {CT_AW{1'b0}};
            word_cnt_q <= {SK_AW{1'b0}};
            idle_q     <= {IDLE_W{1'b0}};
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ct_we_q    <= 1'b0;
            ct_addr_q  <= {CT_AW{1'b0}};
            ct_wdata_q <= 8'h00;
            sk_addr_q  <= {SK_AW{1'b0}};
        end else begin
            state_q    <= state_d;
            ct_cnt_q   <= ct_cnt_d;
            word_cnt_q <= word_cnt_d;
            idle_q     <= idle_d;
            busy_q     <= busy_d;
            loaded_q   <= loaded_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ct_we_q    <= ct_we_d;
            ct_addr_q  <= ct_addr_d;
            ct_wdata_q <= ct_wdata_d;
            sk_addr_q  <= sk_addr_d;
        end
    end

    assign ct_we_o    = ct_we_q;
    assign ct_addr_o  = ct_addr_q;
    assign ct_wdata_o = ct_wdata_q;
    assign sk_addr_o  = sk_addr_q;
    assign busy_o     = busy_q;
    assign loaded_o   = loaded_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
